// File: rtl/spm_driver.sv
// Host-side controller for the bit-serial spm multiplier: holds the multiplicand on x,
// streams the multiplier LSB-first on y and deserializes the serial product from p.
module spm_driver #(
   parameter int SIZE   = 32,
   parameter int LAT    = 1,
   parameter bit SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   mc,
   input  logic [SIZE-1:0]   mp,
   output logic [SIZE-1:0]   x,
   output logic              y,
   output logic              spm_rst,
   input  logic              p,
   output logic [2*SIZE-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CW = $clog2(2*SIZE + LAT + 1);
   localparam logic [CW-1:0] K_LAT  = CW'(LAT);
   localparam logic [CW-1:0] K_TWO  = CW'(2*SIZE);
   localparam logic [CW-1:0] K_LAST = CW'(2*SIZE + LAT - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   k;
   logic [SIZE-1:0] y_sr;
   logic            fill;

   // Arithmetic right shift replicates the captured sign bit, so after SIZE shifts
   // bit 0 already carries the sign extension of mp for the upper half.
   assign fill = SIGNED ? y_sr[SIZE-1] : 1'b0;

   // NOTE: state and datapath registers use non-blocking assignments only, so every
   // flop samples values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         y_sr  <= '0;
         x     <= '0;
         prod  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x    <= mc;
                  y_sr <= mp;
                  prod <= '0;
               end
            end
            CLEAR: k <= '0;
            SHIFT: begin
               k    <= k + CW'(1);
               y_sr <= {fill, y_sr[SIZE-1:1]};
               if (k >= K_LAT)
                  prod <= {p, prod[2*SIZE-1:1]};
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CLEAR;
         CLEAR:   state_nxt = SHIFT;
         SHIFT:   if (k == K_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = !rst && (state == IDLE);
   assign spm_rst   = rst || (state == CLEAR);
   assign out_valid = (state == DONE);
   assign y         = (state == SHIFT) && (k < K_TWO) && y_sr[0];

endmodule

// File: tb/tb_spm_driver.sv
// Self-checking bench: a signed and an unsigned spm_driver run in lockstep, each
// talking to a behavioural spm model with one cycle of p latency.
module tb_spm_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [31:0] mc, mp;

   logic        in_ready_s, y_s, spm_rst_s, out_valid_s;
   logic [31:0] x_s;
   logic [63:0] prod_s;
   logic        p_s = 1'b0;
   logic        in_ready_u, y_u, spm_rst_u, out_valid_u;
   logic [31:0] x_u;
   logic [63:0] prod_u;
   logic        p_u = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spm_driver #(.SIZE(32), .LAT(1), .SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .mc(mc), .mp(mp), .x(x_s), .y(y_s), .spm_rst(spm_rst_s), .p(p_s),
      .prod(prod_s), .out_valid(out_valid_s), .out_ready(out_ready)
   );

   spm_driver #(.SIZE(32), .LAT(1), .SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .mc(mc), .mp(mp), .x(x_u), .y(y_u), .spm_rst(spm_rst_u), .p(p_u),
      .prod(prod_u), .out_valid(out_valid_u), .out_ready(out_ready)
   );

   // Behavioural spm: product bit c depends only on y bits 0..c, registered once.
   function automatic logic [63:0] acc_y(input logic [63:0] ya, input logic yb, input int c);
      return (c < 64) ? (ya | (64'(yb) << c)) : ya;
   endfunction

   function automatic logic prod_bit(input logic [31:0] xv, input logic [63:0] ya,
                                     input int c, input bit sgn);
      logic [63:0] xe, full;
      xe   = sgn ? {{32{xv[31]}}, xv} : {32'b0, xv};
      full = xe * ya;
      return (c < 64) ? full[c] : 1'b0;
   endfunction

   int          cnt_s = 0, cnt_u = 0;
   logic [63:0] yacc_s = '0, yacc_u = '0;

   always @(posedge clk) begin
      if (spm_rst_s) begin
         cnt_s <= 0; yacc_s <= '0; p_s <= 1'b0;
      end else begin
         p_s    <= prod_bit(x_s, acc_y(yacc_s, y_s, cnt_s), cnt_s, 1'b1);
         yacc_s <= acc_y(yacc_s, y_s, cnt_s);
         cnt_s  <= (cnt_s < 64) ? cnt_s + 1 : cnt_s;
      end
   end

   always @(posedge clk) begin
      if (spm_rst_u) begin
         cnt_u <= 0; yacc_u <= '0; p_u <= 1'b0;
      end else begin
         p_u    <= prod_bit(x_u, acc_y(yacc_u, y_u, cnt_u), cnt_u, 1'b0);
         yacc_u <= acc_y(yacc_u, y_u, cnt_u);
         cnt_u  <= (cnt_u < 64) ? cnt_u + 1 : cnt_u;
      end
   end

   function automatic logic [63:0] ref_s(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ae, be;
      ae = {{32{a[31]}}, a};
      be = {{32{b[31]}}, b};
      return ae * be;
   endfunction

   function automatic logic [63:0] ref_u(input logic [31:0] a, input logic [31:0] b);
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction: handshake, latency and busy checks, optional backpressure, accept.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] es, input logic [63:0] eu,
                          input string nm, input bit hold);
      int n;
      bit busy_ok, stable_ok;
      n = 0;
      while (!in_ready_s && n < 200) begin tick(); n++; end
      check({nm, " idle_ready"}, 64'(in_ready_s & in_ready_u), 64'd1);
      mc = a; mp = b; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; mc = ~a; mp = ~b;
      n = 0; busy_ok = 1'b1;
      while (!out_valid_s && n < 200) begin
         if (in_ready_s || in_ready_u) busy_ok = 1'b0;
         tick(); n++;
      end
      if (in_ready_s || in_ready_u) busy_ok = 1'b0;
      check({nm, " latency"}, 64'(n), 64'd66);
      check({nm, " busy"}, 64'(busy_ok), 64'd1);
      check({nm, " prod_signed"}, prod_s, es);
      check({nm, " prod_unsigned"}, prod_u, eu);
      check({nm, " x_held"}, 64'(x_s), 64'(a));
      if (hold) begin
         stable_ok = 1'b1;
         for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            mc = $urandom;
            tick();
            if (prod_s !== es || prod_u !== eu || !out_valid_s || in_ready_s || x_s !== a)
               stable_ok = 1'b0;
         end
         in_valid = 1'b0;
         check({nm, " backpressure_hold"}, 64'(stable_ok), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " valid_drop"}, 64'(out_valid_s | out_valid_u), 64'd0);
      check({nm, " back_to_idle"}, 64'(in_ready_s), 64'd1);
   endtask

   typedef struct {
      logic [31:0] mc;
      logic [31:0] mp;
      logic [63:0] ps;
      logic [63:0] pu;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bit quiet;
      logic [31:0] a, b;

      vecs[0] = '{32'd3,          32'd5,          64'd15,                 64'd15};
      vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'h1,                  64'hFFFFFFFE00000001};
      vecs[2] = '{32'h80000000,   32'h80000000,   64'h4000000000000000,   64'h4000000000000000};
      vecs[3] = '{32'd0,          32'h12345678,   64'd0,                  64'd0};
      vecs[4] = '{32'd7,          32'hFFFFFFFE,   64'hFFFFFFFFFFFFFFF2,   64'h00000006FFFFFFF2};
      vecs[5] = '{32'h80000000,   32'h7FFFFFFF,   64'hC000000080000000,   64'h3FFFFFFF80000000};
      vecs[6] = '{32'h00010000,   32'h00010000,   64'h0000000100000000,   64'h0000000100000000};
      vecs[7] = '{32'hFFFFFFFF,   32'd1,          64'hFFFFFFFFFFFFFFFF,   64'h00000000FFFFFFFF};
      vecs[8] = '{32'd1234,       32'd0,          64'd0,                  64'd0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mc = '0; mp = '0;
      #12;
      check("reset in_ready", 64'(in_ready_s), 64'd0);
      check("reset spm_rst", 64'(spm_rst_s), 64'd1);
      check("reset x_y", {31'd0, y_s, x_s}, 64'd0);
      check("reset prod", prod_s, 64'd0);
      check("reset out_valid", 64'(out_valid_s), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("idle in_ready", 64'(in_ready_s), 64'd1);
      check("idle spm_rst", 64'(spm_rst_s), 64'd0);

      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].mc, vecs[i].mp, vecs[i].ps, vecs[i].pu,
                 $sformatf("vec%0d", i), 1'b0);

      run_txn(32'd11, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFDF, 64'h0000000AFFFFFFDF,
              "hold", 1'b1);

      // Abort in the middle of SHIFT at k=20.
      mc = 32'd5; mp = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 21; i++) tick();
      check("mid_shift spm_rst", 64'(spm_rst_s), 64'd0);
      rst = 1'b1;
      #1;
      check("abort in_ready", 64'(in_ready_s), 64'd0);
      check("abort spm_rst", 64'(spm_rst_s), 64'd1);
      check("abort x_y", {31'd0, y_s, x_s}, 64'd0);
      check("abort prod", prod_s | prod_u, 64'd0);
      check("abort out_valid", 64'(out_valid_s), 64'd0);
      tick();
      rst = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (out_valid_s || out_valid_u) quiet = 1'b0;
      end
      check("abort no_out_valid", 64'(quiet), 64'd1);
      run_txn(32'd7, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFF2, 64'h00000006FFFFFFF2,
              "post_abort", 1'b0);

      // Back-to-back with in_valid and out_ready held high.
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         n = 0;
         while (!in_ready_s && n < 200) begin tick(); n++; end
         check($sformatf("b2b%0d ready", i), 64'(in_ready_s), 64'd1);
         a = $urandom; b = $urandom;
         mc = a; mp = b;
         tick();
         n = 0;
         while (!out_valid_s && n < 200) begin tick(); n++; end
         check($sformatf("b2b%0d latency", i), 64'(n), 64'd66);
         check($sformatf("b2b%0d prod_signed", i), prod_s, ref_s(a, b));
         check($sformatf("b2b%0d prod_unsigned", i), prod_u, ref_u(a, b));
         tick();
         check($sformatf("b2b%0d turnaround", i),
               {62'd0, in_ready_s, out_valid_s}, 64'd2);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
